// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM state encodings and pointer helper.
// Optional build macro UART_ARB_ID_EN adds the ST_ID header state.
package uart_tx_arbiter_pkg;

  localparam int DEF_WIDTH_DATA = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef UART_ARB_ID_EN
    ST_ID   = 2'd1,
`endif
    ST_SEND = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // Next round-robin start position; NB_REQ need not be a power of two.
  function automatic int rr_next(input int idx, input int nb);
    return (idx + 1 >= nb) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter int NB_REQ    = 4,
  parameter int WIDTH_REQ = 2
) (
  input  logic [NB_REQ-1:0]    i_req,
  input  logic [WIDTH_REQ-1:0] i_ptr,
  output logic [WIDTH_REQ-1:0] o_idx,
  output logic                 o_any
);

  logic [NB_REQ-1:0] rot;
  int                sel;

  // Rotate so bit k of rot is requester (ptr + k) mod NB_REQ.
  assign rot = (i_req >> i_ptr) | (i_req << (NB_REQ - int'(i_ptr)));

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    sel   = 0;
    for (int k = NB_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sel   = int'(i_ptr) + k;
        if (sel >= NB_REQ) sel = sel - NB_REQ;
        o_idx = WIDTH_REQ'(sel);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one UART transmitter between NB_REQ byte streams.
// Define UART_ARB_ID_EN to prefix every packet with a header byte carrying the owner index.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int WIDTH_DATA = DEF_WIDTH_DATA,
  parameter int NB_REQ     = 4,
  parameter int WIDTH_REQ  = 2
) (
  input  logic                         i_clk,
  input  logic                         i_nrst,
  input  logic [NB_REQ-1:0]            i_req,
  input  logic [NB_REQ*WIDTH_DATA-1:0] i_data,
  input  logic [NB_REQ-1:0]            i_last,
  output logic [NB_REQ-1:0]            o_ack,
  output logic                         o_busy,
  output logic [WIDTH_REQ-1:0]         o_gnt,
  output logic                         o_we,
  output logic [WIDTH_DATA-1:0]        o_data,
  input  logic                         i_mty
);

  state_e                 state_q;
  logic [WIDTH_REQ-1:0]   gnt_q;
  logic [WIDTH_REQ-1:0]   ptr_q;
  logic                   end_q;
  logic [NB_REQ-1:0]      ack_q;
  logic                   we_q;
  logic [WIDTH_DATA-1:0]  data_q;

  logic [WIDTH_REQ-1:0]   pick_idx;
  logic                   pick_any;
  logic [WIDTH_DATA-1:0]  slot_data;
  logic                   owner_req;
  logic                   owner_last;

  rr_arbiter #(
    .NB_REQ    (NB_REQ),
    .WIDTH_REQ (WIDTH_REQ)
  ) u_rr (
    .i_req (i_req),
    .i_ptr (ptr_q),
    .o_idx (pick_idx),
    .o_any (pick_any)
  );

  assign slot_data  = i_data[int'(gnt_q)*WIDTH_DATA +: WIDTH_DATA];
  assign owner_req  = i_req[gnt_q];
  assign owner_last = i_last[gnt_q];

`ifdef UART_ARB_ID_EN
  logic [WIDTH_DATA-1:0]  hdr_data;

  always_comb begin
    hdr_data                = '0;
    hdr_data[WIDTH_REQ-1:0] = gnt_q;
  end
`endif

  // Strobes default low every cycle so o_we/o_ack are single-cycle pulses.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      end_q   <= 1'b0;
      ack_q   <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      we_q  <= 1'b0;
      ack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            gnt_q   <= pick_idx;
            end_q   <= 1'b0;
`ifdef UART_ARB_ID_EN
            state_q <= ST_ID;
`else
            state_q <= ST_SEND;
`endif
          end
        end
`ifdef UART_ARB_ID_EN
        ST_ID: begin
          if (i_mty) begin
            we_q    <= 1'b1;
            data_q  <= hdr_data;
            state_q <= ST_HOLD;
          end
        end
`endif
        ST_SEND: begin
          if (i_mty && owner_req) begin
            we_q    <= 1'b1;
            data_q  <= slot_data;
            ack_q   <= NB_REQ'(1) << gnt_q;
            end_q   <= owner_last;
            state_q <= ST_HOLD;
          end
        end
        // One dead cycle: i_mty is still high while the uart latches the byte.
        ST_HOLD: begin
          if (end_q) begin
            state_q <= ST_IDLE;
            ptr_q   <= WIDTH_REQ'(rr_next(int'(gnt_q), NB_REQ));
          end else begin
            state_q <= ST_SEND;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_ack  = ack_q;
  assign o_busy = (state_q != ST_IDLE);
  assign o_gnt  = gnt_q;
  assign o_we   = we_q;
  assign o_data = data_q;

endmodule
